// File: rtl/alu_cmd_entry.sv
`default_nettype none
// ============================================================================
// alu_cmd_entry : three-field (A, B, OP) ALU command entry from 4 switches and
// two raw push buttons. Optional debounce via ALU_CMD_ENTRY_DEBOUNCE_EN.
// Revision: 1.0
// ============================================================================
module alu_cmd_entry #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sw,
    input  logic        btn_step,
    input  logic        btn_clr,
    output logic [11:0] cmd,
    output logic        cmd_valid,
    output logic [1:0]  stage
);

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        ENTER_OP = 2'd2
    } state_t;

    logic [1:0] w_btn_raw;
    logic [1:0] w_press;
    logic [1:0] r_arm;

    assign w_btn_raw = {btn_clr, btn_step};

    // Marks when the synchronizers hold real samples again after reset.
    always_ff @(posedge clk) begin
        if (rst) r_arm <= 2'b00;
        else     r_arm <= {r_arm[0], 1'b1};
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic r_s1;
        logic r_s2;
        logic r_lvl_d;
        logic r_blocked;
        logic w_lvl;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1 <= 1'b0;
                r_s2 <= 1'b0;
            end else begin
                r_s1 <= w_btn_raw[gi];
                r_s2 <= r_s1;
            end
        end

`ifdef ALU_CMD_ENTRY_DEBOUNCE_EN
        localparam logic [15:0] c_DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
        logic [15:0] r_cnt;
        logic        r_lvl;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= 16'd0;
                r_lvl <= 1'b0;
            end else if (r_s2 != r_lvl) begin
                if (r_cnt == c_DB_LAST) begin
                    r_lvl <= ~r_lvl;
                    r_cnt <= 16'd0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end else begin
                r_cnt <= 16'd0;
            end
        end

        assign w_lvl = r_lvl;
`else
        assign w_lvl = r_s2;
`endif

        // A button held across reset stays masked until seen released.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_lvl_d   <= 1'b0;
                r_blocked <= 1'b1;
            end else begin
                r_lvl_d <= w_lvl;
                if (r_arm[1] && !r_s2 && !w_lvl)
                    r_blocked <= 1'b0;
            end
        end

        assign w_press[gi] = w_lvl & ~r_lvl_d & ~r_blocked;
    end

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       w_cap_a;
    logic       w_cap_b;
    logic       w_commit;
    logic       w_clear;

    always_comb begin
        w_next   = r_state;
        w_cap_a  = 1'b0;
        w_cap_b  = 1'b0;
        w_commit = 1'b0;
        w_clear  = 1'b0;
        if (w_press[1]) begin
            w_clear = 1'b1;
            w_next  = ENTER_A;
        end else if (w_press[0]) begin
            case (r_state)
                ENTER_A: begin
                    w_cap_a = 1'b1;
                    w_next  = ENTER_B;
                end
                ENTER_B: begin
                    w_cap_b = 1'b1;
                    w_next  = ENTER_OP;
                end
                ENTER_OP: begin
                    w_commit = 1'b1;
                    w_next   = ENTER_A;
                end
                default: w_next = ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ENTER_A;
            r_a       <= 4'd0;
            r_b       <= 4'd0;
            cmd       <= 12'h000;
            cmd_valid <= 1'b0;
        end else begin
            r_state   <= w_next;
            cmd_valid <= w_commit;
            if (w_clear) begin
                r_a <= 4'd0;
                r_b <= 4'd0;
            end
            if (w_cap_a) r_a <= sw;
            if (w_cap_b) r_b <= sw;
            if (w_commit) cmd <= {sw[3], sw[2:0], r_a, r_b};
        end
    end

    assign stage = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_entry.sv
`default_nettype none
// ============================================================================
// tb_alu_cmd_entry : table vectors, hand sequences and random presses checked
// against a field-level entry model. Revision: 1.0
// ============================================================================
module tb_alu_cmd_entry;

`ifdef ALU_CMD_ENTRY_DEBOUNCE_EN
    localparam int LAT = 2 + 4 + 1;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sw = 4'd0;
    logic        btn_step = 1'b0;
    logic        btn_clr = 1'b0;
    logic [11:0] cmd;
    logic        cmd_valid;
    logic [1:0]  stage;

    alu_cmd_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn_step(btn_step), .btn_clr(btn_clr),
        .cmd(cmd), .cmd_valid(cmd_valid), .stage(stage)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int pulses = 0;
    int consec = 0;

    // Model of the entry: field values as plain integers.
    int m_stage = 0, m_a = 0, m_b = 0, m_cmd = 0, m_valid = 0, m_commits = 0;

    typedef struct {
        int         kind;   // 0 step, 1 clear, 2 both
        logic [3:0] v;
        int         st;
        int         c;
        int         vl;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_press(input int kind, input int v);
        m_valid = 0;
        if (kind != 0) begin
            m_stage = 0; m_a = 0; m_b = 0;
        end else if (m_stage == 0) begin
            m_a = v; m_stage = 1;
        end else if (m_stage == 1) begin
            m_b = v; m_stage = 2;
        end else begin
            m_cmd = v * 256 + m_a * 16 + m_b;
            m_valid = 1; m_commits++; m_stage = 0;
        end
    endtask

    task automatic do_press(input int kind, input logic [3:0] v, input int exp_st,
                            input int exp_cmd, input int exp_vl, input int prev_st);
        int k = 0;
        int seen = 0;
        logic [1:0] st0;
        st0 = stage;
        @(negedge clk);
        sw = v;
        btn_step = (kind != 1);
        btn_clr  = (kind != 0);
        for (int i = 1; i <= LAT + 3; i++) begin
            @(posedge clk); #1;
            if (cmd_valid) seen = 1;
            if (k == 0 && (stage != st0 || cmd_valid)) k = i;
        end
        @(negedge clk);
        btn_step = 1'b0;
        btn_clr  = 1'b0;
        repeat (LAT + 4) begin
            @(posedge clk); #1;
            if (cmd_valid) seen = 1;
        end
        chk("stage", int'(stage), exp_st);
        chk("cmd", int'(cmd), exp_cmd);
        chk("cmd_valid_seen", seen, exp_vl);
        if (exp_st != prev_st || exp_vl != 0)
            chk("latency", k, LAT);
    endtask

    // Pulse monitor: counts commits and back-to-back cmd_valid.
    initial begin
        logic prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (cmd_valid) pulses++;
            if (cmd_valid && prev) consec++;
            prev = cmd_valid;
        end
    end

    initial begin
        int prev, changes, k, kind;
        logic [1:0] st;
        logic [3:0] v;

        tbl[0] = '{0, 4'h7, 1, 12'h000, 0};
        tbl[1] = '{0, 4'h3, 2, 12'h000, 0};
        tbl[2] = '{0, 4'h8, 0, 12'h873, 1};
        tbl[3] = '{0, 4'h5, 1, 12'h873, 0};
        tbl[4] = '{0, 4'h9, 2, 12'h873, 0};
        tbl[5] = '{1, 4'h0, 0, 12'h873, 0};
        tbl[6] = '{0, 4'h2, 1, 12'h873, 0};
        tbl[7] = '{0, 4'h4, 2, 12'h873, 0};
        tbl[8] = '{0, 4'hA, 0, 12'hA24, 1};
        tbl[9] = '{1, 4'hF, 0, 12'hA24, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_stage", int'(stage), 0);
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_valid", int'(cmd_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);

        for (int i = 0; i < 10; i++) begin
            prev = m_stage;
            model_press(tbl[i].kind, int'(tbl[i].v));
            do_press(tbl[i].kind, tbl[i].v, tbl[i].st, tbl[i].c, tbl[i].vl, prev);
        end

        // Step and clear together in ENTER_OP: clear wins.
        for (int i = 0; i < 3; i++) begin
            prev = m_stage;
            v = (i == 2) ? 4'hE : 4'(i + 1);
            model_press((i == 2) ? 2 : 0, int'(v));
            do_press((i == 2) ? 2 : 0, v, m_stage, m_cmd, m_valid, prev);
        end
        chk("simul_cmd", int'(cmd), 12'hA24);

        // Reset in ENTER_B with step held: no press until re-pressed.
        prev = m_stage;
        model_press(0, 6);
        do_press(0, 4'h6, m_stage, m_cmd, m_valid, prev);
        @(negedge clk);
        btn_step = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_cmd", int'(cmd), 0);
        chk("rst_mid_stage", int'(stage), 0);
        chk("rst_mid_valid", int'(cmd_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        m_stage = 0; m_a = 0; m_b = 0; m_cmd = 0;
        changes = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (stage != 2'd0 || cmd_valid) changes++;
        end
        @(negedge clk);
        btn_step = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (stage != 2'd0 || cmd_valid) changes++;
        end
        chk("held_through_rst", changes, 0);
        prev = m_stage;
        model_press(0, 6);
        do_press(0, 4'h6, m_stage, m_cmd, m_valid, prev);

`ifdef ALU_CMD_ENTRY_DEBOUNCE_EN
        // Bouncy edge: one capture, timed from the final rising edge.
        model_press(0, 12);
        @(negedge clk);
        sw = 4'hC;
        btn_step = 1'b1;
        @(negedge clk);
        btn_step = 1'b0;
        @(negedge clk);
        btn_step = 1'b1;
        changes = 0;
        k = 0;
        st = stage;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (stage != st) begin
                changes++;
                if (k == 0) k = i;
                st = stage;
            end
        end
        @(negedge clk);
        btn_step = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (stage != st) begin
                changes++;
                st = stage;
            end
        end
        chk("bounce_caps", changes, 1);
        chk("bounce_lat", k, LAT);
        chk("bounce_stage", int'(stage), m_stage);
`endif

        for (int i = 0; i < 40; i++) begin
            kind = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
            v = 4'($urandom);
            prev = m_stage;
            model_press(kind, int'(v));
            do_press(kind, v, m_stage, m_cmd, m_valid, prev);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("valid_pulses", pulses, m_commits);
        chk("valid_consec", consec, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_entry.md
ALU_CMD_ENTRY -- requirements
Module: alu_cmd_entry

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, consecutive stable cycles required before a button level change is accepted (range 1..65535).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sw  input  4  raw operand/opcode switch value, sampled at capture.
REQ-005 btn_step  input  1  raw asynchronous push button; press captures current field and advances.
REQ-006 btn_clr  input  1  raw asynchronous push button; press abandons partial entry.
REQ-007 cmd  output  12  committed command word {en, op[2:0], A[3:0], B[3:0]}, ALU switch-bus format.
REQ-008 cmd_valid  output  1  one-cycle pulse on the cycle cmd takes a new value.
REQ-009 stage  output  2  current entry field: 0 = A, 1 = B, 2 = OP; value 3 never driven.

Function
REQ-010 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-011 A press SHALL be a 0->1 transition of the conditioned (synchronized, debounced) button level; a held button SHALL yield exactly one press.
REQ-012 State machine SHALL have three states ENTER_A, ENTER_B, ENTER_OP; stage SHALL encode the state as in REQ-009.
REQ-013 ENTER_A + step press: sw latched into pending A; next state ENTER_B.
REQ-014 ENTER_B + step press: sw latched into pending B; next state ENTER_OP.
REQ-015 ENTER_OP + step press: cmd <= {sw[3], sw[2:0], pending A, pending B} and cmd_valid = 1 on the following cycle; next state ENTER_A.
REQ-016 cmd SHALL update atomically (all 12 bits in one cycle) and hold its value until the next commit.
REQ-017 Clear press in any state: next state ENTER_A, pending A/B discarded (zeroed), cmd unchanged, no cmd_valid.
REQ-018 Step and clear presses in the same cycle: clear SHALL win; no field captured, no commit.
REQ-019 Presses SHALL have no effect outside the transitions above; states never skipped.
REQ-020 Latency raw step edge -> field capture SHALL be 2 (sync) + DEBOUNCE_CYCLES (with debounce) + 1 cycles, exactly, for a clean edge.
REQ-021 cmd_valid SHALL never be high two consecutive cycles.

Reset
REQ-022 While rst is high at a clock edge: state = ENTER_A, stage = 0, cmd = 12'h000, cmd_valid = 0, pending A/B = 0, synchronizers and debounced levels = 0, debounce counters = 0.
REQ-023 Reset mid-entry SHALL discard the partial entry with no commit; a button held through reset release SHALL NOT produce a press until released and pressed again.

Configuration
REQ-024 Macro ALU_CMD_ENTRY_DEBOUNCE_EN defined: per button, a counter SHALL increment each cycle the synchronized input differs from the debounced level, reset to 0 on any match, and the debounced level SHALL toggle (counter cleared) when the count reaches DEBOUNCE_CYCLES.
REQ-025 Macro not defined: debounce counters SHALL be absent; conditioned level = synchronizer output; latency of REQ-020 becomes 3 cycles; DEBOUNCE_CYCLES ignored.

Verification (DEBOUNCE_EN defined, DEBOUNCE_CYCLES = 4 unless noted)
REQ-026 Full entry: sw=4'h7 step, sw=4'h3 step, sw=4'b1000 step (en=1, op=000) -> stage 0,1,2,0; cmd = 12'h873; single cmd_valid pulse; cmd holds 12'h873 afterwards.
REQ-027 Bounce: btn_step toggles every cycle for 3 cycles then held high 10 cycles -> exactly one capture, occurring 2+4+1 cycles after the final rising edge.
REQ-028 Clear mid-entry: commit 12'h873 as above, then A=4'h5 step, B=4'h9 step, clear press -> stage 0, cmd still 12'h873, no cmd_valid; next full entry uses fresh A/B.
REQ-029 Simultaneous: in ENTER_OP, step and clear conditioned presses on the same cycle -> stage 0, no cmd_valid, cmd unchanged.
REQ-030 Reset: assert rst for 1 cycle in ENTER_B with btn_step held -> cmd = 12'h000, stage 0, cmd_valid 0; no capture until btn_step released and re-pressed.
REQ-031 Macro undefined build: repeat REQ-026 with single-cycle-clean presses -> identical cmd 12'h873, capture 3 cycles after each raw rising edge.
